// File: rtl/id_ex_stage_if.sv
// ID/EX pipeline-register bus: ID operands and controls in, registered EX copies and stall out.
// The bubble_cnt signal exists only when ID_EX_BUBBLE_CNT_EN is defined.
interface id_ex_stage_if;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_imm;
  logic [31:0] id_rs1_data;
  logic [31:0] id_rs2_data;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [11:0] id_ctrl;
  logic        id_RegWEn;
  logic        id_MemRW;
  logic        id_MemRd;
  logic        ex_flush;
  logic        hold;

  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_rs1_data;
  logic [31:0] ex_rs2_data;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [11:0] ex_ctrl;
  logic        ex_RegWEn;
  logic        ex_MemRW;
  logic        ex_MemRd;
  logic        stall;
`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
`endif

  modport master (
    output id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data,
           id_rs1, id_rs2, id_rd, id_ctrl, id_RegWEn, id_MemRW, id_MemRd,
           ex_flush, hold,
    input  ex_valid, ex_pc, ex_imm, ex_rs1_data, ex_rs2_data,
           ex_rs1, ex_rs2, ex_rd, ex_ctrl, ex_RegWEn, ex_MemRW, ex_MemRd,
`ifdef ID_EX_BUBBLE_CNT_EN
           bubble_cnt,
`endif
           stall
  );

  modport slave (
    input  id_valid, id_pc, id_imm, id_rs1_data, id_rs2_data,
           id_rs1, id_rs2, id_rd, id_ctrl, id_RegWEn, id_MemRW, id_MemRd,
           ex_flush, hold,
    output ex_valid, ex_pc, ex_imm, ex_rs1_data, ex_rs2_data,
           ex_rs1, ex_rs2, ex_rd, ex_ctrl, ex_RegWEn, ex_MemRW, ex_MemRd,
`ifdef ID_EX_BUBBLE_CNT_EN
           bubble_cnt,
`endif
           stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX register: 1-cycle capture, bubbles on flush/load-use, freezes on hold; stall is combinational.
// Optional load-use bubble counter on bubble_cnt when ID_EX_BUBBLE_CNT_EN is defined.
module id_ex_stage (
  input logic         clk,
  input logic         rst,
  id_ex_stage_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [11:0] ctrl;
    logic        reg_wen;
    logic        mem_rw;
    logic        mem_rd;
  } slot_t;

  slot_t id_slot;
  slot_t ex_q;
  logic  load_use;
  logic  lu_bubble;

  always_comb begin
    id_slot          = '0;
    id_slot.valid    = bus.id_valid;
    id_slot.pc       = bus.id_pc;
    id_slot.imm      = bus.id_imm;
    id_slot.rs1_data = bus.id_rs1_data;
    id_slot.rs2_data = bus.id_rs2_data;
    id_slot.rs1      = bus.id_rs1;
    id_slot.rs2      = bus.id_rs2;
    id_slot.rd       = bus.id_rd;
    id_slot.ctrl     = bus.id_ctrl;
    // An empty slot must never write registers or memory downstream.
    id_slot.reg_wen  = bus.id_RegWEn & bus.id_valid;
    id_slot.mem_rw   = bus.id_MemRW  & bus.id_valid;
    id_slot.mem_rd   = bus.id_MemRd  & bus.id_valid;
  end

  // Both sources are compared for every format; x0 as a load target never hazards.
  assign load_use = bus.id_valid & ex_q.valid & ex_q.mem_rd & (ex_q.rd != 5'd0) &
                    ((ex_q.rd == bus.id_rs1) | (ex_q.rd == bus.id_rs2));

  assign lu_bubble = ~bus.hold & ~bus.ex_flush & load_use;

  assign bus.stall = bus.hold | (load_use & ~bus.ex_flush);

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else if (bus.hold) begin
      ex_q <= ex_q;
    end else if (bus.ex_flush || load_use) begin
      ex_q <= '0;
    end else begin
      ex_q <= id_slot;
    end
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_q;

  // Counts only load-use bubbles; wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_cnt_q <= 32'd0;
    end else if (lu_bubble) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bus.bubble_cnt = bubble_cnt_q;
`endif

  assign bus.ex_valid    = ex_q.valid;
  assign bus.ex_pc       = ex_q.pc;
  assign bus.ex_imm      = ex_q.imm;
  assign bus.ex_rs1_data = ex_q.rs1_data;
  assign bus.ex_rs2_data = ex_q.rs2_data;
  assign bus.ex_rs1      = ex_q.rs1;
  assign bus.ex_rs2      = ex_q.rs2;
  assign bus.ex_rd       = ex_q.rd;
  assign bus.ex_ctrl     = ex_q.ctrl;
  assign bus.ex_RegWEn   = ex_q.reg_wen;
  assign bus.ex_MemRW    = ex_q.mem_rw;
  assign bus.ex_MemRd    = ex_q.mem_rd;

`ifndef ID_EX_BUBBLE_CNT_EN
  logic unused_lu_bubble;
  assign unused_lu_bubble = lu_bubble;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboarded random/directed bench for id_ex_stage against a slot-level reference model.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [11:0] ctrl;
    logic        reg_wen;
    logic        mem_rw;
    logic        mem_rd;
  } slot_t;

  typedef struct packed {
    slot_t       ex;
    logic        stall;
    logic [31:0] bc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_ex_stage_if bus();
  id_ex_stage dut (.clk(clk), .rst(rst), .bus(bus));

  exp_t        sb[$];
  slot_t       model;
  logic [31:0] model_bc;
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic slot_t rand_slot();
    slot_t s;
    logic [31:0] r;
    r = $urandom;
    s.valid    = (r[1:0] != 2'd0);
    s.pc       = $urandom;
    s.imm      = $urandom;
    s.rs1_data = $urandom;
    s.rs2_data = $urandom;
    s.rs1      = {3'd0, r[3:2]};
    s.rs2      = {3'd0, r[5:4]};
    s.rd       = {3'd0, r[7:6]};
    s.ctrl     = r[19:8];
    s.reg_wen  = r[20];
    s.mem_rw   = r[21];
    s.mem_rd   = r[22];
    return s;
  endfunction

  function automatic slot_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic ld);
    slot_t s;
    s = rand_slot();
    s.valid   = 1'b1;
    s.rs1     = rs1;
    s.rs2     = rs2;
    s.rd      = rd;
    s.mem_rd  = ld;
    s.mem_rw  = 1'b0;
    s.reg_wen = 1'b1;
    return s;
  endfunction

  task automatic drive(input slot_t s, input bit flush, input bit hld, input bit r);
    rst             = r;
    bus.id_valid    = s.valid;
    bus.id_pc       = s.pc;
    bus.id_imm      = s.imm;
    bus.id_rs1_data = s.rs1_data;
    bus.id_rs2_data = s.rs2_data;
    bus.id_rs1      = s.rs1;
    bus.id_rs2      = s.rs2;
    bus.id_rd       = s.rd;
    bus.id_ctrl     = s.ctrl;
    bus.id_RegWEn   = s.reg_wen;
    bus.id_MemRW    = s.mem_rw;
    bus.id_MemRd    = s.mem_rd;
    bus.ex_flush    = flush;
    bus.hold        = hld;
  endtask

  // One cycle: drive ID, record what EX/stall should show now, then advance the model over the edge.
  task automatic apply(input slot_t id, input bit flush, input bit hld, input bit r, input bit preset);
    exp_t e;
    bit   hazard;
    @(posedge clk);
    #1;
    if (preset) begin
`ifdef ID_EX_BUBBLE_CNT_EN
      force dut.bubble_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.bubble_cnt_q;
      model_bc = 32'hFFFF_FFFF;
`else
      $display("counter preset skipped: counter not built");
`endif
    end
    drive(id, flush, hld, r);
    hazard = id.valid && model.valid && model.mem_rd && (model.rd != 0) &&
             ((model.rd == id.rs1) || (model.rd == id.rs2));
    e.ex    = model;
    e.stall = hld || (hazard && !flush);
    e.bc    = model_bc;
    sb.push_back(e);
    if (r) begin
      model    = '0;
      model_bc = 0;
    end else if (hld) begin
      model = model;
    end else if (flush) begin
      model = '0;
    end else if (hazard) begin
      model    = '0;
      model_bc = model_bc + 1;
    end else begin
      model = id;
      if (!id.valid) begin
        model.reg_wen = 1'b0;
        model.mem_rw  = 1'b0;
        model.mem_rd  = 1'b0;
      end
    end
  endtask

  exp_t  mon_e;
  slot_t mon_got;

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e   = sb.pop_front();
      mon_got = {bus.ex_valid, bus.ex_pc, bus.ex_imm, bus.ex_rs1_data, bus.ex_rs2_data,
                 bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_ctrl,
                 bus.ex_RegWEn, bus.ex_MemRW, bus.ex_MemRd};
      n_vec++;
      if (mon_got !== mon_e.ex) begin
        n_bad++;
        $display("FAIL ex_state at %0t: got=%h exp=%h", $time, mon_got, mon_e.ex);
      end
      n_vec++;
      if (bus.stall !== mon_e.stall) begin
        n_bad++;
        $display("FAIL stall at %0t: got=%b exp=%b", $time, bus.stall, mon_e.stall);
      end
`ifdef ID_EX_BUBBLE_CNT_EN
      n_vec++;
      if (bus.bubble_cnt !== mon_e.bc) begin
        n_bad++;
        $display("FAIL bubble_cnt at %0t: got=%h exp=%h", $time, bus.bubble_cnt, mon_e.bc);
      end
`endif
    end
  end

  initial begin
    slot_t lw5, use5, lw0, use0;
    bit fl, hd, rr;
    logic [31:0] r;
    drive(rand_slot(), 1'b0, 1'b0, 1'b1);
    model    = '0;
    model_bc = 0;
    repeat (2) @(posedge clk);

    lw5  = mk(5'd7, 5'd8, 5'd5, 1'b1);
    use5 = mk(5'd5, 5'd9, 5'd6, 1'b0);
    lw0  = mk(5'd3, 5'd4, 5'd0, 1'b1);
    use0 = mk(5'd0, 5'd0, 5'd2, 1'b0);

    apply(rand_slot(), 0, 0, 0, 0);       // post-reset state visible here
    // load-use: one stall, one bubble, then capture
    apply(lw5, 0, 0, 0, 0);
    apply(use5, 0, 0, 0, 0);
    apply(use5, 0, 0, 0, 0);
    apply(rand_slot(), 0, 0, 0, 0);
    // x0 load never hazards
    apply(lw0, 0, 0, 0, 0);
    apply(use0, 0, 0, 0, 0);
    apply(rand_slot(), 0, 0, 0, 0);
    // flush beats load-use
    apply(lw5, 0, 0, 0, 0);
    apply(use5, 1, 0, 0, 0);
    apply(rand_slot(), 0, 0, 0, 0);
    // hold beats flush and load-use for 3 cycles
    apply(lw5, 0, 0, 0, 0);
    repeat (3) apply(use5, 1, 1, 0, 0);
    apply(use5, 1, 0, 0, 0);
    apply(rand_slot(), 0, 0, 0, 0);
    // reset in the middle of a hold
    apply(lw5, 0, 0, 0, 0);
    repeat (2) apply(use5, 0, 1, 0, 0);
    apply(use5, 0, 1, 1, 0);
    apply(rand_slot(), 0, 0, 0, 0);
    // counter wrap on a load-use bubble
    apply(lw5, 0, 0, 0, 0);
    apply(use5, 0, 0, 0, 1);
    apply(use5, 0, 0, 0, 0);
    apply(rand_slot(), 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      r  = $urandom;
      fl = (r[2:0] == 3'd0);
      hd = (r[5:3] == 3'd0);
      rr = (r[10:6] == 5'd0);
      apply(rand_slot(), fl, hd, rr, 0);
    end

    repeat (3) @(posedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got=%0d pending exp=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
